// File: rtl/inport_ctrl_if.sv
// Bus bundle between the input-port controller, its producer and the control unit.
// Controller side uses modport slave; the producer/control-unit side uses modport master.
interface inport_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] DevData;
  logic                  DevValid;
  logic                  DevReady;
  logic                  InReq;
  logic                  InDone;
  logic                  InErr;
  logic [DATA_WIDTH-1:0] PortData;
  logic                  PortStrobe;
  logic [CW-1:0]         Count;
  logic                  Irq;

  modport slave (
    input  DevData, DevValid, InReq,
    output DevReady, InDone, InErr, PortData, PortStrobe, Count, Irq
  );

  modport master (
    output DevData, DevValid, InReq,
    input  DevReady, InDone, InErr, PortData, PortStrobe, Count, Irq
  );
endinterface

// File: rtl/inport_ctrl.sv
// Input-port controller: small FIFO for device words plus a request FSM that strobes the
// head word into the input-port register. Optional data-available interrupt via INPORT_IRQ_EN.
module inport_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned IRQ_LEVEL  = 1
) (
  input  logic          Clock,
  input  logic          Clear_n,
  inport_ctrl_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StLoad = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [15:0]           timer_q, timer_d;
  logic                  err_q, err_d;
  logic [1:0]            state_q, state_d;
  logic                  full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.DevValid & bus.DevReady;
  assign pop   = (state_q == StLoad);

  // Ready is gated by reset so the producer sees no acceptance while the block is held clear.
  assign bus.DevReady   = Clear_n & ~full;
  assign bus.PortData   = mem_q[rd_ptr_q];
  assign bus.PortStrobe = (state_q == StLoad);
  assign bus.InDone     = (state_q == StDone);
  assign bus.InErr      = (state_q == StDone) & err_q;
  assign bus.Count      = count_q;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (bus.InReq && !empty) begin
          state_d = StLoad;
        end else if (bus.InReq) begin
          state_d = StWait;
          timer_d = '0;
        end
      end
      StWait: begin
        // A word pushed this cycle is only seen next cycle; no bypass into LOAD.
        if (!empty) begin
          state_d = StLoad;
        end else if (TIMEOUT != 0 && timer_q == TimeoutLast) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StLoad: begin
        state_d = StDone;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state_q  <= StIdle;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge Clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.DevData;
    end
  end

`ifdef INPORT_IRQ_EN
  logic irq_q;

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (count_d >= CW'(IRQ_LEVEL));
    end
  end

  assign bus.Irq = irq_q;
`else
  assign bus.Irq = 1'b0;
`endif

endmodule
